// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the character-LCD bus arbiter.
// Contents: FSM state encodings, LCD register-select codes and the default
// watchdog limit. Imported by the picker, the top level and the bench.
package lcd_arb_pkg;

    // Arbiter FSM states (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Value of req_cd / drv_cd (drives the LCD rs line)
    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_CHAR = 1'b1;

    // 40 ms at 50 MHz: longest legal driver operation plus margin
    localparam int DEF_TIMEOUT_CYC = 2_000_000;
    localparam int DEF_TO_W        = 21;

endpackage : lcd_arb_pkg

// File: rtl/lcd_bus_arbiter_if.sv
// Bundle of requester-side and driver-side signals of the LCD bus arbiter.
// Latency: none (wires only). Backpressure: requesters hold a byte until req_ack.
// Ports: master = arbiter view, slave = requester/driver/bench view.
interface lcd_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    // requester side
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_cd;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   grant;
    // LCD driver side
    logic [7:0]         drv_data;
    logic               drv_cd;
    logic               drv_start;
    logic               drv_done_tick;
    // status
    logic               busy;
    logic               err_timeout;

    modport master (
        input  req_valid, req_data, req_cd, req_last, drv_done_tick,
        output req_ack, grant, drv_data, drv_cd, drv_start, busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_cd, req_last, drv_done_tick,
        input  req_ack, grant, drv_data, drv_cd, drv_start, busy, err_timeout
    );

endinterface : lcd_bus_arbiter_if

// File: rtl/lcd_rr_pick.sv
// Round-robin picker: first valid requester at or after i_ptr, wrapping modulo N_REQ.
// Latency: combinational. Backpressure: none; result only consumed in IDLE.
// Ports: i_req_valid, i_ptr in; o_pick (one-hot), o_idx, o_any out.
module lcd_rr_pick
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int w_cand;
        w_cand = 0;
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        // Walk candidates in priority order ptr, ptr+1, ... ; the inner loop
        // keeps every bit-select index a loop constant.
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_any && (j == w_cand) && i_req_valid[j]) begin
                    o_any     = 1'b1;
                    o_pick[j] = 1'b1;
                    o_idx     = IDX_W'(j);
                end
            end
        end
    end

endmodule : lcd_rr_pick

// File: rtl/lcd_bus_arbiter.sv
// Shares one character-LCD driver among N_REQ byte streams, round-robin, burst-locked.
// Latency: 1 cycle arbitration, then per byte 1 (ISSUE) + driver time + 1 (GAP).
// Backpressure: a requester holds its byte until req_ack; others wait until the burst ends.
// Ports: clk, rst (sync, active-high); bus = lcd_bus_arbiter_if.master (requesters,
//        driver data/cd/start/done_tick, grant, busy, sticky err_timeout).
module lcd_bus_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic               clk,
    input  logic               rst,
    lcd_bus_arbiter_if.master  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    // FSM and datapath state
    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_ack;
    logic [7:0]       r_drv_data;
    logic             r_drv_cd;
    logic             r_drv_start;
    logic             r_last;
    logic             r_busy;
    logic             r_err;
    logic [TO_W-1:0]  r_wd;

    // Picker results
    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    // Owner's current byte and the pointer value that follows the owner
    logic [7:0]       w_own_data;
    logic             w_own_cd;
    logic             w_own_last;
    logic             w_own_valid;
    logic [IDX_W-1:0] w_owner_inc;

    lcd_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_pick      (w_pick),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_own_data  = bus.req_data[{r_owner, 3'b000} +: 8];
    assign w_own_cd    = bus.req_cd[r_owner];
    assign w_own_last  = bus.req_last[r_owner];
    assign w_own_valid = bus.req_valid[r_owner];
    assign w_owner_inc = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            // A burst in flight is simply abandoned: no ack, pointer back to 0
            r_state     <= IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_ack       <= '0;
            r_drv_data  <= 8'h00;
            r_drv_cd    <= 1'b0;
            r_drv_start <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_wd        <= '0;
        end else begin
            // ack is a single-cycle pulse
            r_ack <= '0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_owner <= w_idx;
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (!w_own_valid) begin
                        // Requester withdrew: end the burst without moving the pointer
                        r_grant <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // last is captured with the byte, so GAP never looks at the
                        // requester's next (possibly already presented) byte
                        r_drv_data  <= w_own_data;
                        r_drv_cd    <= w_own_cd;
                        r_last      <= w_own_last;
                        r_drv_start <= 1'b1;
                        r_wd        <= '0;
                        r_state     <= WAIT;
                    end
                end

                WAIT: begin
                    // done_tick is checked first so it wins over a coincident expiry
                    if (bus.drv_done_tick) begin
                        r_drv_start <= 1'b0;
                        r_ack       <= r_grant;
                        r_state     <= GAP;
                    end else if (r_wd == TO_LAST) begin
                        r_drv_start <= 1'b0;
                        r_err       <= 1'b1;
                        r_grant     <= '0;
                        r_ptr       <= w_owner_inc;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                GAP: begin
                    // drv_start is already low here: one guaranteed low cycle
                    if (r_last) begin
                        r_ptr   <= w_owner_inc;
                        r_grant <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ISSUE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.grant       = r_grant;
    assign bus.drv_data    = r_drv_data;
    assign bus.drv_cd      = r_drv_cd;
    assign bus.drv_start   = r_drv_start;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err;

endmodule : lcd_bus_arbiter
